cmd_router: RTL and testbench

- Parametrised command/response router: pops one command word from the command FIFO and decodes its target field.
- Dispatches the command to one of N_TGT executor ports (TAP and future targets) and waits for that target's done.
- Pushes exactly one response word per command into the response FIFO, including an error word for unknown targets or timeouts.
- Sits between the host FIFO bridge and the per-target executors; replaces the single-target controller.

---
 rtl/cmd_router.sv | 156 +++++++++++++++
 tb/tb_cmd_router.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_router.sv
`default_nettype none
// ============================================================================
// cmd_router : pops a command, dispatches it to one of N_TGT executors and
//              pushes exactly one response (target data or error word) back.
// Revision   : 1.0
// ============================================================================
module cmd_router #(
  parameter int DW      = 32,
  parameter int N_TGT   = 4,
  parameter int TGT_LSB = 28,
  parameter int TGT_W   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       cmd_data,
  input  logic                cmd_waitreq,
  output logic                cmd_rdreq,
  output logic [DW-1:0]       rsp_data,
  output logic                rsp_wrreq,
  input  logic                rsp_waitreq,
  output logic [DW-1:0]       tgt_cmd,
  output logic [N_TGT-1:0]    tgt_run,
  input  logic [N_TGT*DW-1:0] tgt_rsp,
  input  logic [N_TGT-1:0]    tgt_done,
  output logic                busy,
  output logic [15:0]         err_cnt
);

  localparam int               CNT_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [7:0]       ERR_BAD_TGT = 8'h01;
  localparam logic [7:0]       ERR_TIMEOUT = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_DEC  = 3'd2,
    S_EXE  = 3'd3,
    S_WR   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TGT_W-1:0] sel_q, sel_d;
  logic [DW-1:0]    cmd_q, cmd_d;
  logic [DW-1:0]    rsp_q, rsp_d;
  logic [15:0]      err_q, err_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;

  logic             sel_ok;
  logic             sel_done;
  logic [DW-1:0]    sel_rsp;
  logic [N_TGT-1:0] sel_run;
  logic [DW-1:0]    err_word;
  logic [15:0]      err_inc;

  // Decode the latched target index without ever indexing past N_TGT.
  always_comb begin : sel_mux
    sel_ok   = 1'b0;
    sel_done = 1'b0;
    sel_rsp  = '0;
    sel_run  = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (sel_q == TGT_W'(i)) begin
        sel_ok     = 1'b1;
        sel_done   = tgt_done[i];
        sel_rsp    = tgt_rsp[i*DW +: DW];
        sel_run[i] = 1'b1;
      end
    end
  end

  always_comb begin : err_fmt
    err_word              = '0;
    err_word[DW-1 -: 8]   = 8'hEE;
    err_word[8 +: TGT_W]  = sel_q;
    err_inc               = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
  end

  always_comb begin : fsm_next
    state_d   = state_q;
    sel_d     = sel_q;
    cmd_d     = cmd_q;
    rsp_d     = rsp_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    cmd_rdreq = 1'b0;
    rsp_wrreq = 1'b0;
    tgt_run   = '0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (!cmd_waitreq) state_d = S_RD;
      end
      S_RD: begin
        cmd_rdreq = 1'b1;
        cmd_d     = cmd_data;
        sel_d     = cmd_data[TGT_LSB +: TGT_W];
        state_d   = S_DEC;
      end
      S_DEC: begin
        if (!sel_ok) begin
          rsp_d   = err_word | DW'(ERR_BAD_TGT);
          err_d   = err_inc;
          state_d = S_WR;
        end else begin
          tmo_d   = '0;
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        tgt_run = sel_run;
        // done takes priority over a timeout landing on the same cycle
        if (sel_done) begin
          rsp_d   = sel_rsp;
          state_d = S_WR;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          rsp_d   = err_word | DW'(ERR_TIMEOUT);
          err_d   = err_inc;
          state_d = S_WR;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      S_WR: begin
        rsp_wrreq = 1'b1;
        if (!rsp_waitreq) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cmd_q   <= '0;
      rsp_q   <= '0;
      err_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign rsp_data = rsp_q;
  assign tgt_cmd  = cmd_q;
  assign err_cnt  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_router.sv
`default_nettype none
// ============================================================================
// tb_cmd_router : directed scoreboard bench for cmd_router (TIMEOUT = 8).
// Revision      : 1.0
// ============================================================================
module tb_cmd_router;

  localparam int DW      = 32;
  localparam int N_TGT   = 4;
  localparam int TGT_LSB = 28;
  localparam int TGT_W   = 4;
  localparam int TIMEOUT = 8;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DW-1:0]       cmd_data = '0;
  logic                cmd_waitreq = 1'b1;
  logic                cmd_rdreq;
  logic [DW-1:0]       rsp_data;
  logic                rsp_wrreq;
  logic                rsp_waitreq = 1'b0;
  logic [DW-1:0]       tgt_cmd;
  logic [N_TGT-1:0]    tgt_run;
  logic [N_TGT*DW-1:0] tgt_rsp;
  logic [N_TGT-1:0]    tgt_done;
  logic                busy;
  logic [15:0]         err_cnt;

  cmd_router #(
    .DW(DW), .N_TGT(N_TGT), .TGT_LSB(TGT_LSB), .TGT_W(TGT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_data(cmd_data), .cmd_waitreq(cmd_waitreq), .cmd_rdreq(cmd_rdreq),
    .rsp_data(rsp_data), .rsp_wrreq(rsp_wrreq), .rsp_waitreq(rsp_waitreq),
    .tgt_cmd(tgt_cmd), .tgt_run(tgt_run), .tgt_rsp(tgt_rsp), .tgt_done(tgt_done),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_cnt   = 0;
  int n_wr     = 0;
  int last_rd_cyc = 0;
  int last_wr_cyc = 0;
  int run_tot [N_TGT];
  int run_cnt [N_TGT];
  int dly     [N_TGT];
  logic [DW-1:0] rsp_val [N_TGT];
  logic [N_TGT-1:0] model_done;
  logic [N_TGT-1:0] rogue_done = '0;
  logic [DW-1:0] cmd_fifo [$];
  logic [DW-1:0] exp_q [$];
  int wr_hist [$];
  logic prev_wr = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Target executors: done after dly[i] run cycles (0 = never), plus forced stray dones.
  always @(posedge clk) begin
    for (int i = 0; i < N_TGT; i++) run_cnt[i] <= tgt_run[i] ? run_cnt[i] + 1 : 0;
    cyc <= cyc + 1;
  end

  always_comb begin
    tgt_rsp    = '0;
    model_done = '0;
    for (int i = 0; i < N_TGT; i++) begin
      tgt_rsp[i*DW +: DW] = rsp_val[i];
      model_done[i] = tgt_run[i] && (dly[i] != 0) && (run_cnt[i] == dly[i] - 1);
    end
    tgt_done = model_done | rogue_done;
  end

  // Command FIFO model: head presented at the clock, popped on a read acknowledge.
  always @(posedge clk) begin
    if (cmd_rdreq && cmd_fifo.size() != 0) cmd_fifo.delete(0);
    cmd_waitreq <= (cmd_fifo.size() == 0);
    cmd_data    <= (cmd_fifo.size() != 0) ? cmd_fifo[0] : '0;
  end

  // Output monitor and scoreboard consumer.
  always @(negedge clk) begin
    if (cmd_rdreq) begin
      rd_cnt++;
      last_rd_cyc = cyc;
    end
    for (int i = 0; i < N_TGT; i++) if (tgt_run[i]) run_tot[i]++;
    if (tgt_run != '0) chk("run_onehot", 32'($onehot(tgt_run)), 32'd1);
    if (rsp_wrreq && prev_wr) chk("wr_data_stable", rsp_data, prev_data);
    prev_wr   = rsp_wrreq;
    prev_data = rsp_data;
    if (rsp_wrreq && !rsp_waitreq) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL rsp_unexpected: observed %0h expected no write", rsp_data);
      end
      if (exp_q.size() != 0) chk("rsp_data", rsp_data, exp_q.pop_front());
      n_wr++;
      last_wr_cyc = cyc;
      wr_hist.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] c, input logic [DW-1:0] e, input bit has_rsp);
    cmd_fifo.push_back(c);
    if (has_rsp) exp_q.push_back(e);
  endtask

  task automatic wait_wr(input int target, input int budget);
    int k = 0;
    while (n_wr < target && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_wr_budget", 32'(n_wr >= target), 32'd1);
  endtask

  int b_rd, b_wr, k;
  int b_run [N_TGT];
  int sz;

  initial begin
    for (int i = 0; i < N_TGT; i++) begin
      dly[i] = 0; rsp_val[i] = '0; run_tot[i] = 0;
    end

    // Reset state
    tick(3);
    chk("rst_rdreq", 32'(cmd_rdreq), 32'd0);
    chk("rst_wrreq", 32'(rsp_wrreq), 32'd0);
    chk("rst_run", 32'(tgt_run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_tgt_cmd", tgt_cmd, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single command to target 1, done on third EXE cycle
    dly[1] = 3; rsp_val[1] = 32'hCAFE_0001;
    b_rd = rd_cnt; b_run = run_tot;
    send(32'h1000_00AB, 32'hCAFE_0001, 1'b1);
    wait_wr(1, 40);
    chk("t1_rd_pulses", 32'(rd_cnt - b_rd), 32'd1);
    chk("t1_run1_cycles", 32'(run_tot[1] - b_run[1]), 32'd3);
    chk("t1_run_others", 32'(run_tot[0] + run_tot[2] + run_tot[3] - b_run[0] - b_run[2] - b_run[3]), 32'd0);
    chk("t1_latency", 32'(last_wr_cyc - last_rd_cyc), 32'd5);
    chk("t1_tgt_cmd", tgt_cmd, 32'h1000_00AB);
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Unknown target
    b_run = run_tot;
    send(32'h7000_0000, 32'hEE00_0701, 1'b1);
    wait_wr(2, 40);
    chk("t2_latency", 32'(last_wr_cyc - last_rd_cyc), 32'd2);
    chk("t2_no_run", 32'(run_tot[0] + run_tot[1] + run_tot[2] + run_tot[3] - b_run[0] - b_run[1] - b_run[2] - b_run[3]), 32'd0);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    chk("t2_tgt_cmd", tgt_cmd, 32'h7000_0000);

    // Timeout on target 2 while target 1 raises a stray done
    dly[2] = 0; rsp_val[2] = 32'h5555_0002; rogue_done = 4'b0010;
    b_run = run_tot;
    send(32'h2000_0000, 32'hEE00_0202, 1'b1);
    wait_wr(3, 60);
    rogue_done = '0;
    chk("t3_run2_cycles", 32'(run_tot[2] - b_run[2]), 32'd8);
    chk("t3_latency", 32'(last_wr_cyc - last_rd_cyc), 32'd10);
    chk("t3_err_cnt", 32'(err_cnt), 32'd2);

    // Done on the last allowed cycle beats the timeout
    dly[2] = 8;
    b_run = run_tot;
    send(32'h2000_0010, 32'h5555_0002, 1'b1);
    wait_wr(4, 60);
    chk("t3b_run2_cycles", 32'(run_tot[2] - b_run[2]), 32'd8);
    chk("t3b_latency", 32'(last_wr_cyc - last_rd_cyc), 32'd10);
    chk("t3b_err_cnt", 32'(err_cnt), 32'd2);

    // Backpressure with a second command queued
    dly[0] = 1; rsp_val[0] = 32'hD00D_0000;
    dly[3] = 1; rsp_val[3] = 32'hBEEF_0003;
    rsp_waitreq = 1'b1;
    b_rd = rd_cnt; b_wr = n_wr;
    send(32'h0000_0011, 32'hD00D_0000, 1'b1);
    send(32'h3000_0022, 32'hBEEF_0003, 1'b1);
    k = 0;
    while (!rsp_wrreq && k < 40) begin
      tick(1);
      k++;
    end
    chk("t4_wrreq_seen", 32'(rsp_wrreq), 32'd1);
    tick(10);
    chk("t4_wrreq_held", 32'(rsp_wrreq), 32'd1);
    chk("t4_data_held", rsp_data, 32'hD00D_0000);
    chk("t4_no_write", 32'(n_wr - b_wr), 32'd0);
    chk("t4_no_second_rd", 32'(rd_cnt - b_rd), 32'd1);
    rsp_waitreq = 1'b0;
    wait_wr(b_wr + 2, 60);
    chk("t4_rd_total", 32'(rd_cnt - b_rd), 32'd2);
    chk("t4_tgt_cmd", tgt_cmd, 32'h3000_0022);

    // Back-to-back: targets 0, 3, 0 with immediate done
    rsp_val[0] = 32'h0A0A_0000;
    b_wr = n_wr;
    send(32'h0000_0001, 32'h0A0A_0000, 1'b1);
    send(32'h3000_0002, 32'hBEEF_0003, 1'b1);
    send(32'h0000_0003, 32'h0A0A_0000, 1'b1);
    wait_wr(b_wr + 3, 60);
    sz = wr_hist.size();
    chk("t5_gap_1", 32'(wr_hist[sz-2] - wr_hist[sz-3]), 32'd5);
    chk("t5_gap_2", 32'(wr_hist[sz-1] - wr_hist[sz-2]), 32'd5);

    // Asynchronous reset in the middle of EXE
    dly[1] = 0;
    b_wr = n_wr;
    send(32'h1000_0005, '0, 1'b0);
    k = 0;
    while (!tgt_run[1] && k < 40) begin
      tick(1);
      k++;
    end
    chk("t6_run_seen", 32'(tgt_run), 32'b0010);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_run_dropped", 32'(tgt_run), 32'd0);
    chk("t6_busy_dropped", 32'(busy), 32'd0);
    chk("t6_wrreq_low", 32'(rsp_wrreq), 32'd0);
    chk("t6_tgt_cmd_clr", tgt_cmd, 32'd0);
    chk("t6_err_cnt_clr", 32'(err_cnt), 32'd0);
    chk("t6_rsp_data_clr", rsp_data, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("t6_no_write", 32'(n_wr - b_wr), 32'd0);
    dly[1] = 2; rsp_val[1] = 32'h1234_5678;
    b_run = run_tot;
    send(32'h1000_0006, 32'h1234_5678, 1'b1);
    wait_wr(b_wr + 1, 40);
    chk("t6_run1_cycles", 32'(run_tot[1] - b_run[1]), 32'd2);
    chk("t6_latency", 32'(last_wr_cyc - last_rd_cyc), 32'd4);
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);

    tick(3);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
